// File: rtl/demux1_4_stream_if.sv
// rtl/demux1_4_stream_if.sv - producer and consumer signal bundle for the 1-to-4 stream distributor
interface demux1_4_stream_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dout0;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt3;

    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, dout0, dout1, dout2, dout3, out_valid,
        input  cnt0, cnt1, cnt2, cnt3
    );

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, dout0, dout1, dout2, dout3, out_valid,
        output cnt0, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/demux1_4_stream.sv
// rtl/demux1_4_stream.sv - 1-to-4 stream distributor with one-entry output buffers and per-channel counters
module demux1_4_stream #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    demux1_4_stream_if.slave bus
);
    logic [1:0]             ch;
    logic                   in_ready_c;
    logic                   accept;
    logic [3:0]             valid_q;
    logic [3:0]             valid_d;
    logic [3:0][WIDTH-1:0]  data_q;
    logic [3:0][WIDTH-1:0]  data_d;
    logic [3:0][CNT_W-1:0]  cnt_q;
    logic [3:0][CNT_W-1:0]  cnt_d;

    // Inverted select mapping shared with the 4:1 selector: 00->ch3 ... 11->ch0.
    assign ch         = ~bus.sel;
    assign in_ready_c = !rst && (!valid_q[ch] || bus.out_ready[ch]);
    assign accept     = bus.in_valid && in_ready_c;

    always_comb begin
        valid_d = valid_q & ~bus.out_ready;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // A load overrides a drain on the same channel, giving one word per cycle.
        if (accept) begin
            valid_d[ch] = 1'b1;
            data_d[ch]  = bus.din;
            cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.dout0     = data_q[0];
    assign bus.dout1     = data_q[1];
    assign bus.dout2     = data_q[2];
    assign bus.dout3     = data_q[3];
    assign bus.cnt0      = cnt_q[0];
    assign bus.cnt1      = cnt_q[1];
    assign bus.cnt2      = cnt_q[2];
    assign bus.cnt3      = cnt_q[3];
endmodule

// File: tb/tb_demux1_4_stream.sv
// tb/tb_demux1_4_stream.sv - scoreboard bench for the 1-to-4 stream distributor
module tb_demux1_4_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;

    demux1_4_stream_if #(.WIDTH(2), .CNT_W(8)) bus ();

    demux1_4_stream #(.WIDTH(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel queue of words owed to each consumer.
    logic [1:0] exp_q [4][$];
    logic [1:0] last_w [4];
    int         cnt_m [4];

    logic [3:0][1:0] dout_v;
    logic [3:0][7:0] cnt_v;
    assign dout_v = {bus.dout3, bus.dout2, bus.dout1, bus.dout0};
    assign cnt_v  = {bus.cnt3, bus.cnt2, bus.cnt1, bus.cnt0};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_w[k] = 2'd0;
            cnt_m[k]  = 0;
        end
    endfunction

    task automatic cycle(input bit r, input bit v, input bit [1:0] s,
                         input bit [1:0] d, input bit [3:0] ordy);
        int k;
        bit exp_rdy;
        bit acc;
        rst           = r;
        bus.in_valid  = v;
        bus.sel       = s;
        bus.din       = d;
        bus.out_ready = ordy;
        k = 3 - int'(s);
        @(negedge clk);
        exp_rdy = !r && (exp_q[k].size() == 0 || ordy[k]);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (acc) begin
            exp_q[k].push_back(d);
            last_w[k] = d;
            cnt_m[k]  = (cnt_m[k] + 1) % 256;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit [3:0] ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'(i), 2'(i), ordy);
    endtask

    initial begin : monitor
        logic [1:0] w;
        while (!done) begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]),
                          32'(exp_q[k].size() != 0));
                    check($sformatf("dout%0d", k), 32'(dout_v[k]), 32'(last_w[k]));
                    check($sformatf("cnt%0d", k), 32'(cnt_v[k]), 32'(cnt_m[k]));
                    if (exp_q[k].size() != 0 && bus.out_ready[k]) begin
                        w = exp_q[k].pop_front();
                        check($sformatf("delivered%0d", k), 32'(dout_v[k]), 32'(w));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit [1:0] d;
        model_reset();
        cycle(1'b1, 1'b1, 2'd0, 2'd3, 4'hF);
        mon_en = 1'b1;
        cycle(1'b1, 1'b1, 2'd1, 2'd2, 4'hF);

        // Each select value lands on its inverted channel.
        cycle(1'b0, 1'b1, 2'd0, 2'd1, 4'hF);
        cycle(1'b0, 1'b1, 2'd1, 2'd2, 4'hF);
        cycle(1'b0, 1'b1, 2'd2, 2'd3, 4'hF);
        cycle(1'b0, 1'b1, 2'd3, 2'd0, 4'hF);
        idle(2, 4'hF);
        check("map dout3", 32'(bus.dout3), 32'd1);
        check("map dout2", 32'(bus.dout2), 32'd2);
        check("map dout1", 32'(bus.dout1), 32'd3);
        check("map cnt0", 32'(bus.cnt0), 32'd1);

        // Backpressure on channel 3.
        cycle(1'b1, 1'b0, 2'd0, 2'd0, 4'hF);
        cycle(1'b0, 1'b1, 2'd0, 2'd2, 4'b0111);
        cycle(1'b0, 1'b1, 2'd0, 2'd1, 4'b0111);
        check("bp hold dout3", 32'(bus.dout3), 32'd2);
        cycle(1'b0, 1'b1, 2'd0, 2'd1, 4'b1111);
        check("bp dout3", 32'(bus.dout3), 32'd1);
        check("bp cnt3", 32'(bus.cnt3), 32'd2);
        idle(1, 4'hF);

        // Stalled target, producer redirects to channel 0.
        cycle(1'b1, 1'b0, 2'd0, 2'd0, 4'hF);
        cycle(1'b0, 1'b1, 2'd0, 2'd2, 4'b0111);
        cycle(1'b0, 1'b1, 2'd0, 2'd3, 4'b0111);
        cycle(1'b0, 1'b1, 2'd3, 2'd3, 4'b0111);
        check("redirect dout0", 32'(bus.dout0), 32'd3);
        check("redirect dout3", 32'(bus.dout3), 32'd2);
        check("redirect cnt3", 32'(bus.cnt3), 32'd1);
        idle(1, 4'hF);

        // Streaming with counter wrap.
        cycle(1'b1, 1'b0, 2'd0, 2'd0, 4'hF);
        for (int i = 0; i < 300; i++) begin
            d = 2'($urandom_range(0, 3));
            cycle(1'b0, 1'b1, 2'd2, d, 4'hF);
        end
        check("stream cnt1 wrap", 32'(bus.cnt1), 32'd44);
        idle(1, 4'hF);

        // Reset with all channels full and a word on offer.
        for (int s = 0; s < 4; s++) cycle(1'b0, 1'b1, 2'(s), 2'(s + 1), 4'h0);
        check("full out_valid", 32'(bus.out_valid), 32'hF);
        cycle(1'b1, 1'b1, 2'd0, 2'd1, 4'h0);
        check("rst out_valid", 32'(bus.out_valid), 32'h0);
        check("rst cnt3", 32'(bus.cnt3), 32'd0);

        // Idle after reset.
        idle(10, 4'hF);
        check("idle out_valid", 32'(bus.out_valid), 32'h0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
        end
        idle(3, 4'hF);

        done = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demux1_4_stream.md
Name: demux1_4_stream

Overview:
- 1-to-4 stream distributor; the transmit-side counterpart of the team's 4:1 selector.
- Routes each accepted input word to one of four output channels, chosen by sel.
- Uses the same inverted sel mapping as the selector: 00->ch3, 01->ch2, 10->ch1, 11->ch0.
- Each channel has a one-entry registered output buffer with valid/ready handshake and a wrapping transfer counter.
- Placement: between a single producer and four independent consumers.

Parameters:
- WIDTH, 2, data width of din and each dout channel.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  input data word.
- sel  input  2  destination select, sampled in the accept cycle.
- in_valid  input  1  din/sel valid.
- in_ready  output  1  block can accept this cycle (combinational).
- dout0..dout3  output  WIDTH each  channel data (registered).
- out_valid  output  4  bit k = channel k holds a word.
- out_ready  input  4  bit k = consumer k takes the word this cycle.
- cnt0..cnt3  output  CNT_W each  words accepted into channel k since reset.

Behaviour:
- Interface decided: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - out_valid = 4'b0000.
  - dout0..dout3 = 0.
  - cnt0..cnt3 = 0.
  - in_ready forced 0 while rst = 1.
- Channel index: k = 3 - sel (00->3, 01->2, 10->1, 11->0).
- Readiness: in_ready = !rst && (!out_valid[k] || out_ready[k]), evaluated on the current sel.
- Accept: accept = in_valid && in_ready. On accept, at the next edge:
  - doutk <= din.
  - out_valid[k] <= 1.
  - cntk <= cntk + 1, wrapping modulo 2^CNT_W.
- Drain: out_valid[j] && out_ready[j] with no load into channel j -> out_valid[j] <= 0. doutj holds its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one, out_valid stays 1, and the counter increments. This gives full throughput, one word per cycle per channel.
- Latency: exactly 1 cycle from accept to out_valid/dout visible.
- Holding rules:
  - Non-selected channels never change data or counters.
  - A channel's data is stable while out_valid = 1 and out_ready = 0.
- Stall with sel change: if in_valid is held while the target channel is full, the producer may change sel. Routing always follows the sel of the actual accept cycle; the block gives no stickiness guarantee.
- in_valid = 0: no state change except drains. sel and din are don't-care.
- Ordering: per-channel order is preserved. No ordering is defined across channels.
- Counter wrap: 2^CNT_W - 1 -> 0 on the next accept. No saturation, no flag.
- Reset mid-operation: all buffered words are discarded and counters are cleared at the edge. A word offered in the reset cycle is not accepted.
- out_ready on an empty channel is ignored.
- There are no X/don't-care outputs after reset.

Test Plan:
- Reset, then in_valid=1 with sel=00,01,10,11 and din=1,2,3,0 on consecutive cycles, all out_ready=1111 -> each channel's out_valid pulses 1 cycle after its accept:
  - dout3=1, dout2=2, dout1=3, dout0=0.
  - cnt0..cnt3 = 1 each.
  - in_ready stays 1 throughout.
- Backpressure: out_ready[3]=0, send din=2 then din=1 with sel=00 -> first word accepted; in_ready=0 on the second attempt while dout3 holds 2. Raise out_ready[3] -> the second word is accepted in that same cycle, dout3=1 next cycle, cnt3=2.
- Stall-redirect: ch3 full and stalled, in_valid=1 with sel=00 and din=3, then switch sel=11 -> accepted into ch0, dout0=3, and ch3 is unchanged.
- Streaming: 300 back-to-back words to sel=10 with out_ready[1]=1 -> no bubbles, in_ready held 1, cnt1 = 300 mod 256 = 44 (CNT_W=8), and the data sequence on dout1 matches the input.
- Reset mid-stream: rst=1 for 1 cycle with out_valid=1111 and in_valid=1 -> next cycle out_valid=0000, all counters 0, and the word offered during reset is not delivered.
- Idle/empty: out_ready=1111 with in_valid=0 for 10 cycles after reset -> out_valid stays 0000, counters stay 0, dout stays 0.
